// File: rtl/rtc_bus_reader.sv
// RTC register reader: one multiplexed-AD-bus read cycle (address write phases,
// turnaround, read strobe, recovery) per accepted start.
module rtc_bus_reader #(
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] Address,
  input  logic [7:0] ad_bus_in,
  output logic [7:0] ad_bus_out,
  output logic       ad_bus_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_WR_A = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_TURN = 3'd4;
  localparam logic [2:0] S_RD   = 3'd5;
  localparam logic [2:0] S_REC  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [7:0] LAST = 8'(PHASE_CYC - 1);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [7:0] r_addr;
  logic [7:0] w_addr_next;
  logic       w_last;
  logic       w_capture;

  assign w_last    = (r_cnt == LAST);
  assign w_capture = (r_state == S_RD) && w_last;

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_addr_next = r_addr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next      = S_ADDR;
          w_cnt_next  = '0;
          w_addr_next = Address;
        end
      end
      S_DONE: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
      default: begin
        // Timed phases are encoded consecutively, so REC advances into DONE.
        if (w_last) begin
          w_next     = r_state + 3'd1;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they register with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      data_out   <= '0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      ad_n       <= 1'b0;
      ad_bus_oe  <= 1'b0;
      ad_bus_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      if (w_capture) data_out <= ad_bus_in;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      ad_n       <= 1'b0;
      ad_bus_oe  <= 1'b0;
      ad_bus_out <= '0;
      busy       <= (w_next != S_IDLE);
      done       <= (w_next == S_DONE);
      case (w_next)
        S_ADDR, S_HOLD: begin
          cs_n       <= 1'b0;
          ad_bus_oe  <= 1'b1;
          ad_bus_out <= w_addr_next;
        end
        S_WR_A: begin
          cs_n       <= 1'b0;
          wr_n       <= 1'b0;
          ad_bus_oe  <= 1'b1;
          ad_bus_out <= w_addr_next;
        end
        S_TURN, S_REC: begin
          cs_n <= 1'b0;
          ad_n <= 1'b1;
        end
        S_RD: begin
          cs_n <= 1'b0;
          ad_n <= 1'b1;
          rd_n <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Bench for rtc_bus_reader: PHASE_CYC=4 and PHASE_CYC=1 instances checked each
// cycle against a phase-timeline model, plus directed literal expectations.
module tb_rtc_bus_reader;

  localparam int P0 = 4;
  localparam int P1 = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start   [2];
  logic [7:0] addr_in [2];
  logic [7:0] bus_in  [2];
  logic [7:0] bus_out [2];
  logic [7:0] dout    [2];
  logic [7:0] rdata   [2];
  logic       oe [2], cs [2], rd [2], wr [2], adn [2], busy [2], done [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rtc_bus_reader #(.PHASE_CYC(P0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .Address(addr_in[0]),
    .ad_bus_in(bus_in[0]), .ad_bus_out(bus_out[0]), .ad_bus_oe(oe[0]),
    .cs_n(cs[0]), .rd_n(rd[0]), .wr_n(wr[0]), .ad_n(adn[0]),
    .data_out(dout[0]), .busy(busy[0]), .done(done[0]));

  rtc_bus_reader #(.PHASE_CYC(P1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .Address(addr_in[1]),
    .ad_bus_in(bus_in[1]), .ad_bus_out(bus_out[1]), .ad_bus_oe(oe[1]),
    .cs_n(cs[1]), .rd_n(rd[1]), .wr_n(wr[1]), .ad_n(adn[1]),
    .data_out(dout[1]), .busy(busy[1]), .done(done[1]));

  // RTC pad model: drives read data only while the read strobe is low.
  assign bus_in[0] = (rd[0] == 1'b0) ? rdata[0] : 8'hEE;
  assign bus_in[1] = (rd[1] == 1'b0) ? rdata[1] : 8'hEE;

  function automatic int pc_of(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  // Model: k = edges since the accepted start (-1 when idle).
  int         k      [2] = '{-1, -1};
  logic [7:0] m_addr [2] = '{8'h00, 8'h00};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        k[i]      = -1;
        m_data[i] = 8'h00;
      end else if (k[i] < 0) begin
        if (start[i]) begin
          k[i]      = 0;
          m_addr[i] = addr_in[i];
        end
      end else begin
        k[i]++;
        if (k[i] == 5 * pc_of(i)) m_data[i] = rdata[i];
        if (k[i] > 6 * pc_of(i)) k[i] = -1;
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  int   done_cnt  [2] = '{0, 0};
  int   last_done [2] = '{0, 0};
  int   wr21_cnt = 0;
  int   seen33 = 0;

  task automatic cmp(input int i);
    int   p;
    int   ph;
    logic e_cs, e_wr, e_rd, e_oe, e_adn, e_busy, e_done;
    p = pc_of(i);
    if (k[i] < 0) ph = 7;
    else if (k[i] == 6 * p) ph = 6;
    else ph = k[i] / p;
    e_cs   = (ph > 5);
    e_wr   = (ph != 1);
    e_rd   = (ph != 4);
    e_oe   = (ph <= 2);
    e_adn  = (ph == 3) || (ph == 4);
    e_busy = (ph <= 6);
    e_done = (ph == 6);
    chk("cs_n", i, {7'd0, cs[i]}, {7'd0, e_cs});
    chk("wr_n", i, {7'd0, wr[i]}, {7'd0, e_wr});
    chk("rd_n", i, {7'd0, rd[i]}, {7'd0, e_rd});
    chk("ad_bus_oe", i, {7'd0, oe[i]}, {7'd0, e_oe});
    chk("busy", i, {7'd0, busy[i]}, {7'd0, e_busy});
    chk("done", i, {7'd0, done[i]}, {7'd0, e_done});
    chk("data_out", i, dout[i], m_data[i]);
    if (ph != 5 && ph != 6) chk("ad_n", i, {7'd0, adn[i]}, {7'd0, e_adn});
    if (ph <= 2) chk("ad_bus_out", i, bus_out[i], m_addr[i]);
    if (ph == 7) chk("ad_bus_out_idle", i, bus_out[i], 8'h00);
    chk("proto_oe_rd", i, {7'd0, oe[i] & ~rd[i]}, 8'h00);
    chk("proto_wr_rd", i, {7'd0, ~wr[i] & ~rd[i]}, 8'h00);
    if (done[i]) begin
      done_cnt[i]++;
      last_done[i] = cyc;
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) cmp(i);
    if (!wr[0] && bus_out[0] == 8'h21) wr21_cnt++;
    if (oe[0] && bus_out[0] == 8'h33) seen33 = 1;
  end

  task automatic pulse_start(input int i, input logic [7:0] a, output int s);
    @(negedge clk);
    start[i]   = 1'b1;
    addr_in[i] = a;
    @(negedge clk);
    start[i] = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int i, input int n0, input int budget, input string nm);
    int t = 0;
    while (done_cnt[i] == n0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_cnt[i] == n0) begin
      errors++;
      $display("FAIL %s timeout got=no_done exp=done within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int s, n, dummy;
    reset   = 1'b0;
    start   = '{1'b0, 1'b0};
    addr_in = '{8'h00, 8'h00};
    rdata   = '{8'h00, 8'h00};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", i, {7'd0, cs[i]}, 8'h01);
      chk("rst_rd_n", i, {7'd0, rd[i]}, 8'h01);
      chk("rst_wr_n", i, {7'd0, wr[i]}, 8'h01);
      chk("rst_ad_n", i, {7'd0, adn[i]}, 8'h00);
      chk("rst_oe", i, {7'd0, oe[i]}, 8'h00);
      chk("rst_out", i, bus_out[i], 8'h00);
      chk("rst_data", i, dout[i], 8'h00);
      chk("rst_busy", i, {7'd0, busy[i]}, 8'h00);
      chk("rst_done", i, {7'd0, done[i]}, 8'h00);
    end
    @(negedge clk) reset = 1'b1;

    // Basic read
    rdata[0] = 8'h59;
    n = done_cnt[0];
    pulse_start(0, 8'h21, s);
    wait_done(0, n, 60, "basic");
    chki("basic_latency", last_done[0] - s, 24);
    chki("basic_data", int'(dout[0]), 8'h59);
    chki("basic_wr_cycles", wr21_cnt, 4);

    // Start while busy is ignored
    repeat (3) @(negedge clk);
    rdata[0] = 8'h77;
    wr21_cnt = 0;
    n = done_cnt[0];
    pulse_start(0, 8'h21, s);
    repeat (8) @(negedge clk);
    pulse_start(0, 8'h33, dummy);
    wait_done(0, n, 60, "busy_start");
    repeat (30) @(negedge clk);
    chki("busy_one_done", done_cnt[0] - n, 1);
    chki("busy_wr_cycles", wr21_cnt, 4);
    chki("busy_no_33", seen33, 0);
    chki("busy_data", int'(dout[0]), 8'h77);

    // Back-to-back reads
    rdata[0] = 8'h3C;
    n = done_cnt[0];
    pulse_start(0, 8'h21, s);
    wait_done(0, n, 60, "b2b_first");
    rdata[0] = 8'hA5;
    n = done_cnt[0];
    pulse_start(0, 8'h45, s);
    chki("b2b_busy", int'(busy[0]), 1);
    wait_done(0, n, 60, "b2b_second");
    chki("b2b_latency", last_done[0] - s, 24);
    chki("b2b_data", int'(dout[0]), 8'hA5);

    // Reset during RD
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    rdata[0] = 8'h99;
    n = done_cnt[0];
    pulse_start(0, 8'h12, s);
    repeat (17) @(negedge clk);
    chki("rst_in_rd", int'(rd[0]), 0);
    reset = 1'b0;
    #1;
    chki("mid_rst_rd_n", int'(rd[0]), 1);
    chki("mid_rst_cs_n", int'(cs[0]), 1);
    chki("mid_rst_oe", int'(oe[0]), 0);
    chki("mid_rst_busy", int'(busy[0]), 0);
    chki("mid_rst_data", int'(dout[0]), 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chki("mid_rst_no_done", done_cnt[0] - n, 0);
    chki("mid_rst_data_hold", int'(dout[0]), 8'h00);

    // PHASE_CYC=1 instance
    rdata[1] = 8'h0F;
    n = done_cnt[1];
    pulse_start(1, 8'h07, s);
    wait_done(1, n, 20, "p1");
    chki("p1_latency", last_done[1] - s, 6);
    chki("p1_data", int'(dout[1]), 8'h0F);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_reader.md
RTC_BUS_READER -- requirements
Module: rtc_bus_reader

Interface
REQ-001 SHALL have parameter PHASE_CYC, default 4, clock cycles per bus phase; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to perform one RTC register read.
REQ-005 SHALL have port Address  input  8  RTC register address, sampled when start is accepted.
REQ-006 SHALL have port ad_bus_in  input  8  value read back from the multiplexed AD bus pad.
REQ-007 SHALL have port ad_bus_out  output  8  value driven onto the AD bus while ad_bus_oe=1.
REQ-008 SHALL have port ad_bus_oe  output  1  AD bus pad output enable; 1 means drive.
REQ-009 SHALL have port cs_n, rd_n, wr_n  output  1 each  active-low RTC chip select, read strobe and write strobe.
REQ-010 SHALL have port ad_n  output  1  A/D select; 0 means address phase, 1 means data phase.
REQ-011 SHALL have port data_out  output  8  last captured read data.
REQ-012 SHALL have port busy  output  1  high from acceptance of start until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse when data_out is updated.

Function
REQ-014 SHALL use FSM states IDLE, ADDR, WR_A, HOLD, TURN, RD, REC, DONE; every state except IDLE and DONE SHALL last exactly PHASE_CYC cycles, timed by an 8-bit phase counter.
REQ-015 SHALL accept start only in IDLE, latching Address into an internal register and moving to ADDR on the same edge.
REQ-016 SHALL ignore start in every other state; no queuing.
REQ-017 ADDR: cs_n=0, ad_n=0, ad_bus_oe=1, ad_bus_out=latched address, wr_n=1, rd_n=1.
REQ-018 WR_A: as ADDR but wr_n=0, which latches the address into the RTC.
REQ-019 HOLD: as ADDR with wr_n=1, so the address stays driven after the strobe rises.
REQ-020 TURN: ad_bus_oe=0, ad_n=1, cs_n=0, rd_n=1, wr_n=1 (bus turnaround).
REQ-021 RD: as TURN but rd_n=0; ad_bus_in SHALL be sampled into data_out on the last RD cycle (phase counter = PHASE_CYC-1).
REQ-022 REC: rd_n=1, cs_n=0, ad_bus_oe=0.
REQ-023 DONE: cs_n=1, done=1 for exactly one cycle, then IDLE unconditionally.
REQ-024 With start sampled at edge 0, done SHALL be high in cycle 6*PHASE_CYC+1 (25 cycles for the default).
REQ-025 busy SHALL be 1 in ADDR..DONE and 0 in IDLE.
REQ-026 ad_bus_oe and rd_n=0 SHALL never both be asserted; wr_n=0 and rd_n=0 SHALL never coexist.
REQ-027 In IDLE: cs_n=rd_n=wr_n=1, ad_n=0, ad_bus_oe=0, ad_bus_out=8'h00.
REQ-028 data_out SHALL hold its value between completed reads and SHALL be unchanged by an aborted read.
REQ-029 All bus control outputs SHALL be registered (glitch-free).
REQ-030 If PHASE_CYC=1, each phase SHALL be one cycle and done SHALL come 7 cycles after the start edge.

Reset
REQ-031 While reset=0, regardless of clk: FSM=IDLE, phase counter=0, cs_n=rd_n=wr_n=1, ad_n=0, ad_bus_oe=0, ad_bus_out=8'h00, data_out=8'h00, busy=0, done=0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately, releasing the bus and strobes with no done pulse.
REQ-033 After reset deassertion, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-034 Basic read: PHASE_CYC=4, start with Address=8'h21, bus model returns 8'h59 during rd_n=0 -> ad_bus_out=8'h21 while wr_n=0 for 4 cycles, data_out=8'h59, done in cycle 25.
REQ-035 Start while busy: second start at cycle 10 with Address=8'h33 -> ignored, address phase of the first read unchanged, exactly one done.
REQ-036 Back-to-back: start asserted in the cycle after done -> accepted; second read returns 8'hA5 and data_out changes only at the second capture.
REQ-037 Reset mid-RD: reset=0 in cycle 18 -> cs_n, rd_n =1 and ad_bus_oe=0 asynchronously, data_out stays 8'h00, no done.
REQ-038 PHASE_CYC=1 build: read of 8'h0F -> every phase one cycle, done in cycle 7.
REQ-039 Protocol checker in all tests: the bus is never driven while rd_n=0, wr_n and rd_n are never low together, and cs_n=0 throughout ADDR..REC.
